wormhole_port_allocator: RTL and testbench
==========================================

// Module: wormhole_port_allocator
// PURPOSE
//  Per-output-port allocator for the 5-port mesh router. Arbitrates header flits from the L,N,E,W,S
//  input FIFOs with rotating round-robin priority, then locks the output to the winner for the whole
//  packet using the header length field. Drives the crossbar one-hot select and the per-input read grant.
//  One instance sits per output port between the input-side LBDR/flow-control and the crossbar.
// PARAMETERS
//  NPORTS     5   requesters, index 0=L 1=N 2=E 3=W 4=S (sel/grant bit order)
//  LEN_W      12  width of packet length field (flits, header included)
//  FID_W      3   width of flit id field
// PORTS
//  clk        in   1            router clock
//  rst        in   1            asynchronous, active-low reset
//  req        in   NPORTS       input i has a flit routed to this output (LBDR port & !empty)
//  flit_id    in   NPORTS*FID_W flit id of head flit of each input, input i at [i*FID_W +: FID_W]
//  pkt_len    in   NPORTS*LEN_W length field of head flit of each input, input i at [i*LEN_W +: LEN_W]
//  ready_in   in   1            downstream (next router/NI) can accept a flit this cycle
//  grant      out  NPORTS       one-hot, combinational: flit of input i transfers this cycle (FIFO rd_en)
//  sel        out  NPORTS       one-hot registered crossbar select of current owner; 0 when idle
//  busy       out  1            1 while a packet holds this output (state HOLD)
//  proto_err  out  1            one-cycle pulse: premature TAIL or HEADER seen mid-packet
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, rr_ptr=0 (L highest), cnt=0, owner=0, sel=0, busy=0,
//    proto_err=0; grant=0 while in reset. Reset mid-packet abandons the packet; no flush.
//  - Transfer condition: grant[i]=1 implies req[i]=1 and ready_in=1; at most one grant bit set.
//  - IDLE: candidates = req[i] && flit_id[i]==FLIT_HEADER. If ready_in and any candidate: winner = first
//    candidate scanning i = rr_ptr, rr_ptr+1, ... mod NPORTS; grant[winner]=1 same cycle (0-cycle latency).
//    Next edge: len_eff = (pkt_len==0) ? 1 : pkt_len. If len_eff==1 -> stay IDLE, rr_ptr=winner+1 mod
//    NPORTS. Else -> HOLD, owner=winner, sel=onehot(winner), cnt=len_eff-1, busy=1.
//    Non-header requests in IDLE are ignored (never granted). ready_in=0 -> no grant, no state change.
//  - HOLD: grant[owner] = req[owner] && ready_in; all other grant bits 0 regardless of req.
//    On transfer: cnt<=cnt-1. If cnt==1 (last flit) -> IDLE, sel=0, busy=0, rr_ptr=owner+1 mod NPORTS.
//    Stall (req[owner]=0 or ready_in=0): hold all state, sel stays asserted.
//  - Errors (on a HOLD transfer): flit_id==FLIT_TAIL with cnt>1 -> proto_err pulse, end packet as above.
//    flit_id==FLIT_HEADER -> proto_err pulse, flit still transferred, count continues.
//  - cnt is LEN_W bits, never wraps: decrement only in HOLD with cnt>=1.
//  - rr_ptr advances only when a packet completes; a single-flit packet completes in IDLE.
//  - Back-to-back: packet ending at edge k allows a new header grant in cycle k (first IDLE cycle).
// STRUCTURE
//  - Shared include state_defines.v: FLIT_HEADER=3'b001, FLIT_BODY=3'b010, FLIT_TAIL=3'b100,
//    ALLOC_IDLE=1'b0, ALLOC_HOLD=1'b1. LEN_W/FID_W defaults from parameters.v.
//  - One sub-module: rr_pick (combinational NPORTS-way rotating priority picker: req, ptr -> one-hot).
//  - Top: 2-state FSM, rr_ptr, owner, cnt registers, grant/sel decode. Five instances per router.
// TESTING
//  1 Reset: assert rst=0 mid-HOLD (owner=E, cnt=5) -> sel=0,busy=0,grant=0 immediately; after release
//    headers on L and S with rr_ptr=0 -> L granted first.
//  2 Round robin: N,E,W hold 2-flit packets continuously, ready_in=1 -> ownership order N,E,W,N,...;
//    each packet exactly 2 grant cycles, no idle cycle between packets.
//  3 Lock: owner=L pkt_len=4, header on S arrives cycle 1 -> S grant stays 0 until L's 4th flit;
//    S granted the cycle after.
//  4 Backpressure: owner=W pkt_len=3, ready_in=0 for 3 cycles after header -> grant=0, cnt=2, sel=W
//    stable; on ready_in=1 two grants then IDLE.
//  5 Single-flit and zero length: L header pkt_len=1 then pkt_len=0 -> one grant each, busy never 1,
//    rr_ptr advances to 1 after first.
//  6 Protocol: owner=N pkt_len=5, TAIL at 2nd transfer -> proto_err=1 one cycle, back to IDLE, rr_ptr=2.

Source files
------------

// File: rtl/wormhole_port_allocator_pkg.sv
// wormhole_port_allocator_pkg: shared widths, flit id codes and FSM state type for the output-port allocator
package wormhole_port_allocator_pkg;
  localparam int NPORTS = 5;
  localparam int LEN_W = 12;
  localparam int FID_W = 3;
  localparam int PTR_W = $clog2(NPORTS);
  localparam logic [FID_W-1:0] FLIT_HEADER = 3'b001;
  localparam logic [FID_W-1:0] FLIT_BODY = 3'b010;
  localparam logic [FID_W-1:0] FLIT_TAIL = 3'b100;
  typedef enum logic {ALLOC_IDLE = 1'b0, ALLOC_HOLD = 1'b1} alloc_state_t;
  typedef logic [PTR_W-1:0] ptr_t;
  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(NPORTS - 1)) ? '0 : p + 1'b1;
  endfunction
endpackage

// File: rtl/wormhole_port_allocator_if.sv
// wormhole_port_allocator_if: request/grant bundle between input-side flow control and one output allocator
interface wormhole_port_allocator_if;
  import wormhole_port_allocator_pkg::*;
  logic [NPORTS-1:0] req;
  logic [NPORTS*FID_W-1:0] flit_id;
  logic [NPORTS*LEN_W-1:0] pkt_len;
  logic ready_in;
  logic [NPORTS-1:0] grant;
  logic [NPORTS-1:0] sel;
  logic busy;
  logic proto_err;
  modport master (output req, flit_id, pkt_len, ready_in, input grant, sel, busy, proto_err);
  modport slave (input req, flit_id, pkt_len, ready_in, output grant, sel, busy, proto_err);
endinterface

// File: rtl/wormhole_port_allocator_rr_pick.sv
// wormhole_port_allocator_rr_pick: rotating-priority picker, first request at or after ptr wins
module wormhole_port_allocator_rr_pick
  import wormhole_port_allocator_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  ptr_t              ptr,
  output logic [NPORTS-1:0] pick,
  output ptr_t              idx
);
  // scan from farthest to nearest so the nearest request overwrites
  always_comb begin
    pick = '0;
    idx = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NPORTS]) begin
        idx = ptr_t'((int'(ptr) + k) % NPORTS);
        pick = NPORTS'(1) << idx;
      end
    end
  end
endmodule

// File: rtl/wormhole_port_allocator.sv
// wormhole_port_allocator: round-robin header arbitration, then locks the output for the packet length
module wormhole_port_allocator
  import wormhole_port_allocator_pkg::*;
(
  input logic clk,
  input logic rst,
  wormhole_port_allocator_if.slave bus
);
  alloc_state_t state, state_n;
  ptr_t rr_ptr, rr_n, owner, owner_n, win;
  logic [LEN_W-1:0] cnt, cnt_n, len_win, len_eff;
  logic [NPORTS-1:0] hdr, pick, sel_n;
  logic [FID_W-1:0] own_fid;
  logic perr_n, xfer;
  always_comb begin
    hdr = '0;
    for (int i = 0; i < NPORTS; i++) hdr[i] = bus.req[i] && bus.flit_id[i*FID_W +: FID_W] == FLIT_HEADER;
  end
  wormhole_port_allocator_rr_pick u_pick (.req(hdr), .ptr(rr_ptr), .pick(pick), .idx(win));
  assign len_win = bus.pkt_len[int'(win)*LEN_W +: LEN_W];
  assign len_eff = (len_win == '0) ? LEN_W'(1) : len_win;
  assign own_fid = bus.flit_id[int'(owner)*FID_W +: FID_W];
  assign xfer = state == ALLOC_HOLD && bus.req[owner] && bus.ready_in;
  assign bus.busy = state == ALLOC_HOLD;
  assign bus.grant = !rst ? '0 :
                     state == ALLOC_IDLE ? (bus.ready_in ? pick : '0) :
                     xfer ? NPORTS'(1) << owner : '0;
  always_comb begin
    state_n = state;
    rr_n = rr_ptr;
    owner_n = owner;
    cnt_n = cnt;
    perr_n = 1'b0;
    if (state == ALLOC_IDLE) begin
      if (bus.ready_in && |hdr) begin
        if (len_eff == LEN_W'(1)) rr_n = ptr_inc(win);
        else begin
          state_n = ALLOC_HOLD;
          owner_n = win;
          cnt_n = len_eff - 1'b1;
        end
      end
    end else if (xfer) begin
      perr_n = own_fid == FLIT_HEADER || (own_fid == FLIT_TAIL && cnt > LEN_W'(1));
      // a premature tail closes the packet just like the last counted flit
      cnt_n = (own_fid == FLIT_TAIL || cnt <= LEN_W'(1)) ? '0 : cnt - 1'b1;
      if (cnt_n == '0) begin
        state_n = ALLOC_IDLE;
        rr_n = ptr_inc(owner);
      end
    end
    sel_n = (state_n == ALLOC_HOLD) ? NPORTS'(1) << owner_n : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ALLOC_IDLE;
      rr_ptr <= '0;
      owner <= '0;
      cnt <= '0;
      bus.sel <= '0;
      bus.proto_err <= 1'b0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_n;
      owner <= owner_n;
      cnt <= cnt_n;
      bus.sel <= sel_n;
      bus.proto_err <= perr_n;
    end
  end
endmodule

// File: tb/tb_wormhole_port_allocator.sv
// tb_wormhole_port_allocator: directed scenario tasks with hand-computed grant/sel/busy/proto_err values
module tb_wormhole_port_allocator;
  import wormhole_port_allocator_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  wormhole_port_allocator_if bus ();
  wormhole_port_allocator dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic clr();
    bus.req = '0;
    bus.flit_id = '0;
    bus.pkt_len = '0;
  endtask

  task automatic put(input int p, input logic [FID_W-1:0] fid, input int len);
    bus.req[p] = 1'b1;
    bus.flit_id[p*FID_W +: FID_W] = fid;
    bus.pkt_len[p*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clr();
    bus.ready_in = 1'b1;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    clr();
    bus.ready_in = 1'b1;
    put(0, FLIT_HEADER, 2);
    #1;
    tests++; if (bus.grant !== 5'b00000) begin fails++; $display("FAIL rst_grant: got %b want 00000", bus.grant); end
    tests++; if (bus.sel !== 5'b00000 || bus.busy !== 1'b0 || bus.proto_err !== 1'b0) begin fails++; $display("FAIL rst_state: sel %b busy %b perr %b want 00000 0 0", bus.sel, bus.busy, bus.proto_err); end
    tick();
    rst = 1'b1;
    clr();
    put(2, FLIT_HEADER, 6);
    #1;
    tests++; if (bus.grant !== 5'b00100) begin fails++; $display("FAIL rst_e_hdr: got %b want 00100", bus.grant); end
    tick();
    tests++; if (bus.sel !== 5'b00100 || bus.busy !== 1'b1) begin fails++; $display("FAIL rst_e_hold: sel %b busy %b want 00100 1", bus.sel, bus.busy); end
    put(2, FLIT_BODY, 6);
    #1;
    rst = 1'b0;
    #1;
    tests++; if (bus.sel !== 5'b00000 || bus.busy !== 1'b0 || bus.grant !== 5'b00000) begin fails++; $display("FAIL rst_mid: sel %b busy %b grant %b want 00000 0 00000", bus.sel, bus.busy, bus.grant); end
    tick();
    rst = 1'b1;
    clr();
    put(0, FLIT_HEADER, 1);
    put(4, FLIT_HEADER, 1);
    #1;
    tests++; if (bus.grant !== 5'b00001) begin fails++; $display("FAIL rst_l_first: got %b want 00001", bus.grant); end
    tick();
  endtask

  task automatic test_round_robin();
    int order[4] = '{1, 2, 3, 1};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      int p = order[c/2];
      clr();
      put(1, FLIT_HEADER, 2);
      put(2, FLIT_HEADER, 2);
      put(3, FLIT_HEADER, 2);
      if (c % 2 == 1) put(p, FLIT_BODY, 2);
      #1;
      tests++; if (bus.grant !== NPORTS'(1) << p) begin fails++; $display("FAIL rr_grant c%0d: got %b want %b", c, bus.grant, NPORTS'(1) << p); end
      tick();
      tests++; if (bus.busy !== (c % 2 == 0)) begin fails++; $display("FAIL rr_busy c%0d: got %b want %b", c, bus.busy, c % 2 == 0); end
    end
    clr();
  endtask

  task automatic test_lock();
    do_reset();
    put(0, FLIT_HEADER, 4);
    #1;
    tests++; if (bus.grant !== 5'b00001) begin fails++; $display("FAIL lock_hdr: got %b want 00001", bus.grant); end
    tick();
    for (int c = 1; c < 4; c++) begin
      put(0, (c == 3) ? FLIT_TAIL : FLIT_BODY, 4);
      put(4, FLIT_HEADER, 1);
      #1;
      tests++; if (bus.grant !== 5'b00001) begin fails++; $display("FAIL lock_hold c%0d: got %b want 00001", c, bus.grant); end
      tick();
    end
    clr();
    put(4, FLIT_HEADER, 1);
    #1;
    tests++; if (bus.grant !== 5'b10000) begin fails++; $display("FAIL lock_s_next: got %b want 10000", bus.grant); end
    tick();
    clr();
  endtask

  task automatic test_backpressure();
    do_reset();
    put(3, FLIT_HEADER, 3);
    #1;
    tests++; if (bus.grant !== 5'b01000) begin fails++; $display("FAIL bp_hdr: got %b want 01000", bus.grant); end
    tick();
    put(3, FLIT_BODY, 3);
    bus.ready_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++; if (bus.grant !== 5'b00000) begin fails++; $display("FAIL bp_stall_grant c%0d: got %b want 00000", c, bus.grant); end
      tick();
      tests++; if (bus.sel !== 5'b01000 || bus.busy !== 1'b1) begin fails++; $display("FAIL bp_stall_sel c%0d: sel %b busy %b want 01000 1", c, bus.sel, bus.busy); end
    end
    bus.ready_in = 1'b1;
    #1;
    tests++; if (bus.grant !== 5'b01000) begin fails++; $display("FAIL bp_body: got %b want 01000", bus.grant); end
    tick();
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL bp_busy_mid: got %b want 1", bus.busy); end
    put(3, FLIT_TAIL, 3);
    #1;
    tests++; if (bus.grant !== 5'b01000) begin fails++; $display("FAIL bp_tail: got %b want 01000", bus.grant); end
    tick();
    tests++; if (bus.busy !== 1'b0 || bus.sel !== 5'b00000) begin fails++; $display("FAIL bp_end: busy %b sel %b want 0 00000", bus.busy, bus.sel); end
    clr();
  endtask

  task automatic test_single_flit();
    do_reset();
    put(0, FLIT_HEADER, 1);
    #1;
    tests++; if (bus.grant !== 5'b00001) begin fails++; $display("FAIL sf_len1: got %b want 00001", bus.grant); end
    tick();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL sf_len1_busy: got %b want 0", bus.busy); end
    put(0, FLIT_HEADER, 0);
    #1;
    tests++; if (bus.grant !== 5'b00001) begin fails++; $display("FAIL sf_len0: got %b want 00001", bus.grant); end
    tick();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL sf_len0_busy: got %b want 0", bus.busy); end
    put(0, FLIT_HEADER, 1);
    put(1, FLIT_HEADER, 1);
    #1;
    tests++; if (bus.grant !== 5'b00010) begin fails++; $display("FAIL sf_rr1: got %b want 00010", bus.grant); end
    tick();
    clr();
    put(2, FLIT_BODY, 3);
    #1;
    tests++; if (bus.grant !== 5'b00000) begin fails++; $display("FAIL sf_nonhdr: got %b want 00000", bus.grant); end
    tick();
    clr();
  endtask

  task automatic test_proto_tail();
    do_reset();
    put(1, FLIT_HEADER, 5);
    #1;
    tests++; if (bus.grant !== 5'b00010) begin fails++; $display("FAIL pt_hdr: got %b want 00010", bus.grant); end
    tick();
    put(1, FLIT_BODY, 5);
    #1;
    tests++; if (bus.grant !== 5'b00010) begin fails++; $display("FAIL pt_body: got %b want 00010", bus.grant); end
    tick();
    tests++; if (bus.proto_err !== 1'b0) begin fails++; $display("FAIL pt_noerr: got %b want 0", bus.proto_err); end
    put(1, FLIT_TAIL, 5);
    #1;
    tests++; if (bus.grant !== 5'b00010) begin fails++; $display("FAIL pt_tail: got %b want 00010", bus.grant); end
    tick();
    tests++; if (bus.proto_err !== 1'b1 || bus.busy !== 1'b0 || bus.sel !== 5'b00000) begin fails++; $display("FAIL pt_err: perr %b busy %b sel %b want 1 0 00000", bus.proto_err, bus.busy, bus.sel); end
    clr();
    put(0, FLIT_HEADER, 1);
    put(1, FLIT_HEADER, 1);
    put(2, FLIT_HEADER, 1);
    #1;
    tests++; if (bus.grant !== 5'b00100) begin fails++; $display("FAIL pt_rr2: got %b want 00100", bus.grant); end
    tick();
    tests++; if (bus.proto_err !== 1'b0) begin fails++; $display("FAIL pt_pulse: got %b want 0", bus.proto_err); end
    clr();
  endtask

  task automatic test_proto_header();
    do_reset();
    put(0, FLIT_HEADER, 3);
    #1;
    tick();
    #1;
    tests++; if (bus.grant !== 5'b00001) begin fails++; $display("FAIL ph_grant: got %b want 00001", bus.grant); end
    tick();
    tests++; if (bus.proto_err !== 1'b1 || bus.busy !== 1'b1) begin fails++; $display("FAIL ph_err: perr %b busy %b want 1 1", bus.proto_err, bus.busy); end
    put(0, FLIT_TAIL, 3);
    #1;
    tests++; if (bus.grant !== 5'b00001) begin fails++; $display("FAIL ph_tail: got %b want 00001", bus.grant); end
    tick();
    tests++; if (bus.proto_err !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL ph_end: perr %b busy %b want 0 0", bus.proto_err, bus.busy); end
    clr();
  endtask

  initial begin
    clr();
    bus.ready_in = 1'b1;
    test_reset();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_single_flit();
    test_proto_tail();
    test_proto_header();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
